fpmult_round_pack: RTL

Rounding, exponent-rebias and packing stage of the 8-bit floating-point multiplier (1 sign, 3-bit exponent bias 3, 4-bit fraction with hidden one). Sits directly downstream of the multiplier execute stage and consumes its product sign, normalized 4-bit exponent sum, normalized 4-bit fraction and round-up bit. Produces the packed 8-bit product through a 2-stage valid/ready pipeline. Also flags overflow and underflow and keeps saturating exception counters.

---
 rtl/fpmult_pkg.sv | 20 ++
 rtl/fpmult_sat_counter.sv | 30 +++
 rtl/fpmult_round_pack.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fpmult_pkg.sv
// fpmult_pkg: shared widths, limits and the packed result layout for the
// 8-bit floating-point multiplier (1 sign, 3-bit exponent bias 3, 4-bit
// fraction with hidden one).
package fpmult_pkg;

  localparam int DEF_EW    = 3;
  localparam int DEF_MW    = 4;
  localparam int DEF_BIAS  = 3;
  localparam int DEF_CNT_W = 8;

  localparam logic [DEF_EW-1:0] EXP_MAX = '1;
  localparam logic [DEF_MW-1:0] MAN_MAX = '1;

  typedef struct packed {
    logic              sign;
    logic [DEF_EW-1:0] exp;
    logic [DEF_MW-1:0] man;
  } fp8_t;

endpackage

// File: rtl/fpmult_sat_counter.sv
// fpmult_sat_counter: saturating event counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event (ignored once at all-ones)
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
module fpmult_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fpmult_round_pack.sv
// fpmult_round_pack: round, rebias and pack stage of the fp8 multiplier.
// Two-stage valid/ready pipeline:
//   S1 rounds the fraction and folds the rounding carry into the exponent.
//   S2 removes one bias, saturates/flushes and registers the packed result.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready           : upstream handshake
//   in_sign/in_exp/in_man/in_rnd: product sign, doubly-biased exponent sum,
//                                 normalized fraction, round-up request
//   out_valid/out_ready         : downstream handshake
//   out_data, out_ovf, out_unf  : packed result and its exception flags
//   clr_cnt                     : synchronous clear of both counters
//   ovf_cnt, unf_cnt            : saturating counts of delivered exceptions
module fpmult_round_pack
  import fpmult_pkg::*;
#(
  parameter int EW    = DEF_EW,
  parameter int MW    = DEF_MW,
  parameter int BIAS  = DEF_BIAS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EW:0]      in_exp,
  input  logic [MW-1:0]    in_man,
  input  logic             in_rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   out_data,
  output logic             out_ovf,
  output logic             out_unf,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  localparam int E6_W = EW + 2;
  // e6 limits: above EXP top + BIAS saturates, below BIAS flushes to zero.
  localparam logic [E6_W-1:0] E6_OVF_LIM = E6_W'((1 << EW) - 1 + BIAS);
  localparam logic [E6_W-1:0] E6_UNF_LIM = E6_W'(BIAS);

  logic s2_adv, s1_adv;

  // S1 state
  logic            s1_valid_q;
  logic            s1_sign_q;
  logic [MW-1:0]   s1_frac_q, s1_frac_d;
  logic [E6_W-1:0] s1_e6_q, s1_e6_d;
  logic [MW:0]     m5;

  // S2 state
  logic            out_valid_q;
  logic [EW+MW:0]  out_data_q, out_data_d;
  logic            out_ovf_q, out_ovf_d;
  logic            out_unf_q, out_unf_d;
  logic [EW-1:0]   exp_field;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Rounding a fraction of all ones wraps it to zero and bumps the exponent.
  always_comb begin
    m5        = {1'b0, in_man} + {{MW{1'b0}}, in_rnd};
    s1_frac_d = m5[MW] ? '0 : m5[MW-1:0];
    s1_e6_d   = {1'b0, in_exp} + {{(E6_W-1){1'b0}}, m5[MW]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_frac_q  <= '0;
      s1_e6_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_sign;
        s1_frac_q <= s1_frac_d;
        s1_e6_q   <= s1_e6_d;
      end
    end
  end

  // Comparing e6 against bias-shifted limits avoids a signed subtraction.
  always_comb begin
    exp_field  = EW'(s1_e6_q - E6_UNF_LIM);
    out_ovf_d  = 1'b0;
    out_unf_d  = 1'b0;
    out_data_d = {s1_sign_q, exp_field, s1_frac_q};
    if (s1_e6_q > E6_OVF_LIM) begin
      out_ovf_d  = 1'b1;
      out_data_d = {s1_sign_q, {EW{1'b1}}, {MW{1'b1}}};
    end else if (s1_e6_q < E6_UNF_LIM) begin
      out_unf_d  = 1'b1;
      out_data_d = {s1_sign_q, {EW{1'b0}}, {MW{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
        out_ovf_q  <= out_ovf_d;
        out_unf_q  <= out_unf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

  logic out_hs;
  assign out_hs = out_valid_q && out_ready;

  fpmult_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_hs && out_ovf_q),
    .clr   (clr_cnt),
    .cnt   (ovf_cnt)
  );

  fpmult_sat_counter #(.CNT_W(CNT_W)) u_unf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_hs && out_unf_q),
    .clr   (clr_cnt),
    .cnt   (unf_cnt)
  );

endmodule
